serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_pkg.sv | 13 +
 rtl/fa_cell.sv | 13 +
 rtl/serial_add_ctrl.sv | 104 ++++++++++
 tb/tb_serial_add_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: controller state
// encoding and the default operand width.
package serial_add_ctrl_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder, time-shared by the serial adder controller.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first through a
// single full-adder cell, then presents {cout, sum} with a one-cycle done pulse.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             cell_s, cell_c;

  fa_cell u_fa_cell (
    .x (sh_a_q[0]),
    .y (sh_b_q[0]),
    .z (carry_q),
    .s (cell_s),
    .c (cell_c)
  );

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sum_d   = sum_q;
    count_d = count_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sh_a_d  = a;
          sh_b_d  = b;
          carry_d = cin;
          count_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // New sum bit enters at the MSB so the LSB lands in place after WIDTH shifts.
        sum_d   = (sum_q >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));
        carry_d = cell_c;
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
        count_d = count_q + CW'(1);
        if (count_q == LastCnt) begin
          cout_d  = cell_c;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sum_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH = 1, 8 and 13.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start1, cin1, busy1, done1, cout1;
  logic [0:0]  a1, b1, sum1;
  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start13, cin13, busy13, done13, cout13;
  logic [12:0] a13, b13, sum13;

  int checks = 0;
  int fails  = 0;

  logic [7:0] ha [64];
  logic [7:0] hb [64];
  logic       hc [64];

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );
  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_add_ctrl #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .cin(cin13),
    .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int w, input logic [31:0] av, input logic [31:0] bv,
                     input logic cv, input logic st);
    case (w)
      1: begin a1 = av[0:0]; b1 = bv[0:0]; cin1 = cv; start1 = st; end
      8: begin a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv; start8 = st; end
      default: begin a13 = av[12:0]; b13 = bv[12:0]; cin13 = cv; start13 = st; end
    endcase
  endtask

  function automatic logic dn(input int w);
    return (w == 1) ? done1 : (w == 8) ? done8 : done13;
  endfunction
  function automatic logic bs(input int w);
    return (w == 1) ? busy1 : (w == 8) ? busy8 : busy13;
  endfunction
  function automatic logic co(input int w);
    return (w == 1) ? cout1 : (w == 8) ? cout8 : cout13;
  endfunction
  function automatic logic [31:0] sm(input int w);
    return (w == 1) ? 32'(sum1) : (w == 8) ? 32'(sum8) : 32'(sum13);
  endfunction

  // One full operation: accept, scramble inputs, count busy cycles, check result.
  task automatic op(input int w, input logic [31:0] av, input logic [31:0] bv,
                    input logic cv, input string tag);
    logic [31:0] mask;
    logic [32:0] full;
    int n, nb;
    mask = (32'd1 << w) - 32'd1;
    full = {1'b0, av & mask} + {1'b0, bv & mask} + 33'(cv);
    drv(w, av, bv, cv, 1'b1);
    tick();
    drv(w, ~av, ~bv, ~cv, 1'b0);
    n  = 0;
    nb = 0;
    while (!dn(w) && n < 64) begin
      if (bs(w)) nb++;
      tick();
      n++;
    end
    chk({tag, " done"}, 64'(dn(w)), 64'd1);
    chk({tag, " latency"}, 64'(nb), 64'(w));
    chk({tag, " busy@done"}, 64'(bs(w)), 64'd0);
    chk({tag, " sum"}, 64'(sm(w)), 64'(full[31:0] & mask));
    chk({tag, " cout"}, 64'(co(w)), 64'(full[w]));
    tick();
    chk({tag, " pulse"}, 64'(dn(w)), 64'd0);
  endtask

  initial begin
    int nd, nbz, last, n;
    logic [8:0] exp9;
    rst = 1'b1;
    drv(1, 0, 0, 0, 0);
    drv(8, 0, 0, 0, 0);
    drv(13, 0, 0, 0, 0);
    tick();
    tick();
    for (int w = 1; w <= 13; w++) begin
      if (w == 1 || w == 8 || w == 13) begin
        chk($sformatf("reset busy w%0d", w), 64'(bs(w)), 64'd0);
        chk($sformatf("reset done w%0d", w), 64'(dn(w)), 64'd0);
        chk($sformatf("reset sum w%0d", w), 64'(sm(w)), 64'd0);
        chk($sformatf("reset cout w%0d", w), 64'(co(w)), 64'd0);
      end
    end
    rst = 1'b0;
    tick();

    op(8, 32'h00, 32'h00, 1'b0, "zero");
    op(8, 32'hFF, 32'h01, 1'b0, "ff+01");
    op(8, 32'hA5, 32'h5A, 1'b1, "a5+5a+1");
    op(8, 32'h3C, 32'h42, 1'b0, "3c+42");

    // start during RUN and during DONE must be ignored
    drv(8, 32'h10, 32'h20, 1'b0, 1'b1);
    tick();
    drv(8, 32'h10, 32'h20, 1'b0, 1'b0);
    tick();
    drv(8, 32'hFF, 32'hFF, 1'b0, 1'b1);
    tick();
    drv(8, 32'hFF, 32'hFF, 1'b0, 1'b0);
    n = 0;
    while (!done8 && n < 32) begin
      tick();
      n++;
    end
    chk("ignore done", 64'(done8), 64'd1);
    chk("ignore sum", 64'(sum8), 64'h30);
    chk("ignore cout", 64'(cout8), 64'd0);
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    nd  = 0;
    nbz = 0;
    repeat (12) begin
      tick();
      if (done8) nd++;
      if (busy8) nbz++;
    end
    chk("ignore extra done", 64'(nd), 64'd0);
    chk("ignore extra busy", 64'(nbz), 64'd0);

    // reset in RUN cycle 4 discards the operation
    drv(8, 32'hFF, 32'hFF, 1'b1, 1'b1);
    tick();
    drv(8, 32'hFF, 32'hFF, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    chk("midrst busy before", 64'(busy8), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst busy", 64'(busy8), 64'd0);
    chk("midrst done", 64'(done8), 64'd0);
    chk("midrst sum", 64'(sum8), 64'd0);
    chk("midrst cout", 64'(cout8), 64'd0);
    nd  = 0;
    nbz = 0;
    repeat (12) begin
      tick();
      if (done8) nd++;
      if (busy8) nbz++;
    end
    chk("midrst no done", 64'(nd), 64'd0);
    chk("midrst idle", 64'(nbz), 64'd0);
    op(8, 32'h12, 32'h34, 1'b1, "after rst");

    // start held high: accepts every WIDTH+2 cycles, first at edge 0
    nd   = 0;
    last = -1;
    for (int i = 0; i < 49; i++) begin
      ha[i] = 8'(i * 37 + 5);
      hb[i] = 8'(i * 91 + 3);
      hc[i] = i[0];
      drv(8, 32'(ha[i]), 32'(hb[i]), hc[i], 1'b1);
      tick();
      if (done8) begin
        nd++;
        if (last < 0) chk("b2b first done", 64'(i), 64'd8);
        else chk("b2b spacing", 64'(i - last), 64'd10);
        exp9 = {1'b0, ha[(i >= 8) ? i - 8 : 0]} + {1'b0, hb[(i >= 8) ? i - 8 : 0]}
             + 9'(hc[(i >= 8) ? i - 8 : 0]);
        chk("b2b result", 64'({cout8, sum8}), 64'(exp9));
        last = i;
      end
    end
    start8 = 1'b0;
    chk("b2b done count", 64'(nd), 64'd5);
    tick();
    tick();

    for (int k = 0; k < 8; k++) begin
      op(1, 32'(k[2]), 32'(k[1]), k[0], $sformatf("w1 %0d", k));
    end

    for (int k = 0; k < 600; k++) begin
      op(8, $urandom, $urandom, 1'($urandom), "rand w8");
    end
    for (int k = 0; k < 400; k++) begin
      op(13, $urandom, $urandom, 1'($urandom), "rand w13");
    end
    op(13, 32'h1FFF, 32'h1FFF, 1'b1, "w13 max");
    op(8, 32'hFF, 32'hFF, 1'b1, "w8 max");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
